load_store_unit: RTL and testbench
==================================

# load_store_unit

Request-side initiator for the byte-addressable `memory` block, with the memory's combinational read and posedge write.
- Accepts one load or store at a time from the core over a valid/ready handshake.
- Sequences the memory's `read_en_i` / `write_en_i` / `addr_i` / `data_i` ports.
- Returns a single-cycle response carrying sign/zero-extended load data or an error flag.
- Sub-word stores (byte, half) are done as read-modify-write, because the memory always writes a full 4-byte window.

## Interface
- `AWIDTH`, 32: address width.
- `DWIDTH`, 32: data width (fixed at 32; other values unsupported).
- `BASE_ADDR`, 32'h01000000: first byte address of the memory.
- `MEM_DEPTH`, 1048576: memory size in bytes; must equal the memory block's `MEM_DEPTH`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  unit can accept a request.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned_i`  in  1  zero-extend load (1) or sign-extend (0).
- `req_addr_i`  in  AWIDTH  byte address; unaligned addresses are legal.
- `req_wdata_i`  in  DWIDTH  store data; uses the low 8/16/32 bits.
- `rsp_valid_o`  out  1  one-cycle response pulse.
- `rsp_rdata_o`  out  DWIDTH  extended load data; 0 for stores and errors.
- `rsp_err_o`  out  1  request rejected; no memory write was issued.
- `mem_addr_o`  out  AWIDTH  to memory `addr_i`.
- `mem_wdata_o`  out  DWIDTH  to memory `data_i`.
- `mem_read_en_o`  out  1  to memory `read_en_i`.
- `mem_write_en_o`  out  1  to memory `write_en_i`.
- `mem_rdata_i`  in  DWIDTH  from memory `data_o`.

## Operation
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- `req_ready_o` = (state == IDLE) && !rst.
- A request is accepted on a clock edge where valid && ready. At acceptance the unit latches addr, we, size, unsigned and wdata.
- Offset: off = addr − BASE_ADDR, computed modulo 2^AWIDTH, so addresses below BASE wrap to a large offset.
- Error conditions; an error goes IDLE→RESP with `rsp_err_o`=1 and no memory enable asserted:
  - size == 11;
  - a load with off + nbytes > MEM_DEPTH;
  - any store with off > MEM_DEPTH−4 (the memory silently drops writes in its last 3 bytes; the unit reports this instead).
- Transitions after a legal accept:
  - Load: IDLE→LOAD→RESP.
  - Word store: IDLE→WRITE→RESP.
  - Byte/half store: IDLE→RMW_RD→WRITE→RESP.
  - RESP→IDLE unconditionally.
- LOAD:
  - Drive read_en=1 and addr=latched addr.
  - Capture `mem_rdata_i` at the edge.
  - Extension: byte {24{s&d[7]}, d[7:0]}; half {16{s&d[15]}, d[15:0]}; word unchanged. Here s = !unsigned.
- RMW_RD:
  - Drive read_en=1 and capture the old word W.
  - Merge: byte {W[31:8], wd[7:0]}; half {W[31:16], wd[15:0]}.
- WRITE: drive write_en=1, addr=latched addr, wdata=merged word (or the latched word for word stores), for exactly one cycle.
- Memory outputs depend only on state and latched registers; there is no combinational path from `req_*` to `mem_*`.
- Outside LOAD/RMW_RD/WRITE all `mem_*` outputs are 0.

## Timing
- Reset: state=IDLE.
  - While `rst` is high, `req_ready_o`, `rsp_valid_o`, `rsp_err_o`, `mem_read_en_o` and `mem_write_en_o` are 0.
  - `rsp_rdata_o`, `mem_addr_o` and `mem_wdata_o` are 0.
- Reset mid-operation: the transaction is abandoned with no response. `mem_write_en_o` is forced to 0 in any cycle with `rst`=1, so a write is never issued.
- Accept at edge N. Cycle numbers below count clock edges from N.
- Load: LOAD during cycle N→N+1, `rsp_valid_o` high in cycle N+1→N+2, next accept possible at N+3.
- Word store: memory write occurs at edge N+1; response in the following cycle.
- Sub-word store: read in cycle N→N+1, write at edge N+2, response in cycle N+2→N+3.
- Error: response in cycle N→N+1.
- Throughput:
  - 1 request per 3 cycles: load or word store;
  - 1 per 4 cycles: sub-word store;
  - 1 per 2 cycles: error.
- `req_valid_i` while busy is ignored. The requester must hold the request until ready; no internal queue.
- `rsp_valid_o` has no backpressure; it is a single-cycle pulse that the requester must capture.

## Structure
- `lsu_pkg`:
  - `size_e` enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - `lsu_state_e` enum;
  - BYTE_SIZE=8.
- Sub-module `lsu_align`, combinational:
  - load extension (size, unsigned, raw) → rdata;
  - store merge (size, old, wdata) → word.
- Top module: FSM, latches, range check.

## Test plan
1. Word store 32'hDEADBEEF to 32'h01000010, then signed word load at the same address → rsp_rdata 32'hDEADBEEF, err 0; write_en high exactly 1 cycle.
2. Byte store 8'hAA to 32'h01000011 over the word from test 1 → memory word at 32'h01000010 reads 32'hDEADAAEF. Signed byte load at 32'h01000011 → 32'hFFFFFFAA; unsigned → 32'h000000AA.
3. Half store 16'h8001 to 32'h01000013 (unaligned), then signed half load → 32'hFFFF8001; bytes 0x10..0x12 unchanged.
4. Errors, each with rsp_err 1 one cycle after accept and no read/write enable:
   - store to BASE+MEM_DEPTH−3;
   - word load at BASE+MEM_DEPTH−2;
   - address 32'h00FFFFFF;
   - size 11.
5. req_valid held continuously with back-to-back requests → ready low while busy; requests accepted at the cycle spacing given in Timing; no request lost or duplicated.
6. rst asserted in the WRITE cycle of a byte store → no write lands (memory word unchanged), no rsp_valid; after reset ready=1 and the next load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// and the byte count of an access.
package lsu_pkg;

  localparam int BYTE_SIZE = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } lsu_state_e;

  // Size code 2'b11 is illegal and is rejected separately; it maps to 4 here.
  function automatic logic [2:0] size_nbytes(logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: sign/zero extension of loaded data and
// merging of sub-word store data into the old memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_raw,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);

  localparam int HALF = 2 * BYTE_SIZE;

  logic w_sext;
  assign w_sext = !i_unsigned;

  always_comb begin
    o_rdata  = i_raw;
    o_merged = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_rdata  = {{(32-BYTE_SIZE){w_sext & i_raw[BYTE_SIZE-1]}}, i_raw[BYTE_SIZE-1:0]};
        o_merged = {i_raw[31:BYTE_SIZE], i_wdata[BYTE_SIZE-1:0]};
      end
      SZ_HALF: begin
        o_rdata  = {{(32-HALF){w_sext & i_raw[HALF-1]}}, i_raw[HALF-1:0]};
        o_merged = {i_raw[31:HALF], i_wdata[HALF-1:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for the byte-addressable memory:
// range checks at accept, read-modify-write for sub-word stores, one-cycle response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned       AWIDTH    = 32,
  parameter int unsigned       DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000,
  parameter int unsigned       MEM_DEPTH = 1048576
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_rdata_i
);

  localparam logic [AWIDTH:0]   LP_DEPTH     = {1'b0, AWIDTH'(MEM_DEPTH)};
  localparam logic [AWIDTH-1:0] LP_STORE_MAX = AWIDTH'(MEM_DEPTH - 4);

  lsu_state_e        r_state;
  logic [AWIDTH-1:0] r_addr;
  size_e             r_size;
  logic              r_unsigned;
  logic [DWIDTH-1:0] r_wdata;
  logic [DWIDTH-1:0] r_rdata;
  logic              r_err;

  logic [AWIDTH-1:0] w_off;
  logic [AWIDTH:0]   w_end;
  logic              w_err;
  logic              w_rd;
  logic              w_wr;
  logic              w_rsp;
  logic [DWIDTH-1:0] w_load_data;
  logic [DWIDTH-1:0] w_merged;

  // Offset wraps modulo 2^AWIDTH, so addresses below the base look huge and fail.
  assign w_off = req_addr_i - BASE_ADDR;
  assign w_end = {1'b0, w_off} + {{(AWIDTH-2){1'b0}}, size_nbytes(req_size_i)};
  assign w_err = (req_size_i == 2'b11) ||
                 (req_we_i ? (w_off > LP_STORE_MAX) : (w_end > LP_DEPTH));

  lsu_align u_align (
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_raw      (mem_rdata_i),
    .i_wdata    (r_wdata),
    .o_rdata    (w_load_data),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_size     <= SZ_WORD;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_addr     <= req_addr_i;
            r_size     <= (req_size_i == 2'b11) ? SZ_WORD : size_e'(req_size_i);
            r_unsigned <= req_unsigned_i;
            r_wdata    <= req_wdata_i;
            r_rdata    <= '0;
            r_err      <= w_err;
            if (w_err)                     r_state <= RESP;
            else if (!req_we_i)            r_state <= LOAD;
            else if (req_size_i == SZ_WORD) r_state <= WRITE;
            else                           r_state <= RMW_RD;
          end
        end
        LOAD: begin
          r_rdata <= w_load_data;
          r_state <= RESP;
        end
        RMW_RD: begin
          // The merged word replaces the store data so WRITE drives one register.
          r_wdata <= w_merged;
          r_state <= WRITE;
        end
        WRITE:   r_state <= RESP;
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Every output is gated by rst so an in-flight write can never reach memory.
  assign w_rd  = ((r_state == LOAD) || (r_state == RMW_RD)) && !rst;
  assign w_wr  = (r_state == WRITE) && !rst;
  assign w_rsp = (r_state == RESP) && !rst;

  assign req_ready_o    = (r_state == IDLE) && !rst;
  assign rsp_valid_o    = w_rsp;
  assign rsp_err_o      = w_rsp && r_err;
  assign rsp_rdata_o    = w_rsp ? r_rdata : '0;
  assign mem_read_en_o  = w_rd;
  assign mem_write_en_o = w_wr;
  assign mem_addr_o     = (w_rd || w_wr) ? r_addr : '0;
  assign mem_wdata_o    = w_wr ? r_wdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, request-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_load_store_unit;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int unsigned DEPTH = 1048576;
  localparam int          MAXC  = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_read_en_o, mem_write_en_o;

  load_store_unit #(.AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, exp, cyc);
    end
  endfunction

  // Memory seen by the DUT: 4-byte little-endian window, combinational read,
  // posedge write, writes in the last 3 bytes silently dropped.
  logic [7:0]  env_mem [DEPTH];
  logic [31:0] env_off;
  assign env_off = mem_addr_o - BASE;

  always_comb begin
    mem_rdata_i = '0;
    for (int i = 0; i < 4; i++)
      if (longint'(env_off) + i < longint'(DEPTH)) mem_rdata_i[8*i +: 8] = env_mem[env_off + i];
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) env_mem[i] = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_write_en_o && env_off <= DEPTH - 4)
        for (int i = 0; i < 4; i++) env_mem[env_off + i] <= mem_wdata_o[8*i +: 8];
    end
  end

  function automatic logic [31:0] env_word(int unsigned off);
    return {env_mem[off+3], env_mem[off+2], env_mem[off+1], env_mem[off]};
  endfunction

  // Reference model: byte-granular memory and a per-cycle expectation schedule.
  typedef struct {
    bit busy, rd, wr, rsp, err, pw;
    bit [31:0] addr, wdata, rdata, pdata;
    int unsigned poff;
    int pn;
  } exp_t;

  exp_t sched [MAXC];
  exp_t zero_e;
  logic [7:0] ref_mem [int unsigned];

  function automatic logic [7:0] ref_rd(int unsigned o);
    return ref_mem.exists(o) ? ref_mem[o] : 8'h00;
  endfunction

  function automatic void schedule(int n, bit we, logic [1:0] sz, bit uns,
                                   logic [31:0] addr, logic [31:0] wd);
    logic [31:0] off;
    int nb;
    bit bad;
    longint v;
    logic [31:0] w;
    off = addr - BASE;
    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    bad = (sz == 2'b11) ||
          (!we && (longint'(off) + nb > longint'(DEPTH))) ||
          (we && (longint'(off) > longint'(DEPTH) - 4));
    if (bad) begin
      sched[n].busy = 1; sched[n].rsp = 1; sched[n].err = 1;
    end else if (!we) begin
      v = 0;
      for (int i = 0; i < nb; i++) v |= longint'(ref_rd(off + i)) << (8*i);
      if (!uns && nb < 4 && v[8*nb-1]) v |= (-64'sd1) << (8*nb);
      sched[n].busy = 1; sched[n].rd = 1; sched[n].addr = addr;
      sched[n+1].busy = 1; sched[n+1].rsp = 1; sched[n+1].rdata = v[31:0];
    end else begin
      w = 0;
      for (int i = 0; i < 4; i++)
        w[8*i +: 8] = (i < nb) ? wd[8*i +: 8] : ref_rd(off + i);
      if (nb < 4) begin
        sched[n].busy = 1; sched[n].rd = 1; sched[n].addr = addr;
        n++;
      end
      sched[n].busy = 1; sched[n].wr = 1; sched[n].addr = addr; sched[n].wdata = w;
      sched[n].pw = 1; sched[n].poff = off; sched[n].pn = nb; sched[n].pdata = wd;
      sched[n+1].busy = 1; sched[n+1].rsp = 1;
    end
  endfunction

  int rsp_count = 0, rd_pulses = 0, wr_pulses = 0;
  int last_acc = 0, last_rsp = 0;
  logic [31:0] last_rdata;
  logic last_err;
  int acc_q [$];

  // Compare process: every cycle, DUT outputs against the model schedule.
  initial begin
    exp_t e;
    int c;
    forever begin
      @(negedge clk);
      c = cyc;
      if (rst) for (int i = c; i < MAXC; i++) sched[i] = zero_e;
      e = sched[c];
      chk("ready", req_ready_o, 32'(!rst && !e.busy));
      chk("rsp_valid", rsp_valid_o, 32'(e.rsp));
      chk("rsp_err", rsp_err_o, 32'(e.err));
      chk("rsp_rdata", rsp_rdata_o, e.rdata);
      chk("mem_read_en", mem_read_en_o, 32'(e.rd));
      chk("mem_write_en", mem_write_en_o, 32'(e.wr));
      chk("mem_addr", mem_addr_o, (e.rd || e.wr) ? e.addr : 32'h0);
      if (!e.rd) chk("mem_wdata", mem_wdata_o, e.wr ? e.wdata : 32'h0);
      if (e.pw && !rst)
        for (int i = 0; i < e.pn; i++) ref_mem[e.poff + i] = e.pdata[8*i +: 8];
      if (mem_read_en_o) rd_pulses++;
      if (mem_write_en_o) wr_pulses++;
      if (rsp_valid_o) begin
        rsp_count++; last_rdata = rsp_rdata_o; last_err = rsp_err_o; last_rsp = c;
      end
      if (req_valid_i && req_ready_o) begin
        acc_q.push_back(c + 1); last_acc = c + 1;
      end
      if (!rst && !e.busy && req_valid_i)
        schedule(c + 1, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i);
    end
  end

  task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int nrd, output int nwr);
    int t, rc0, rp0, wp0;
    @(posedge clk); #1;
    rc0 = rsp_count; rp0 = rd_pulses; wp0 = wr_pulses;
    req_valid_i = 1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wd;
    t = 0;
    @(negedge clk);
    while (!req_ready_o && t < 50) begin @(negedge clk); t++; end
    chk("accept_in_time", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
    req_valid_i = 0;
    t = 0;
    while (rsp_count == rc0 && t < 50) begin @(negedge clk); #1; t++; end
    chk("rsp_in_time", 32'(rsp_count != rc0), 32'd1);
    rd = last_rdata; er = last_err; lat = last_rsp - last_acc;
    nrd = rd_pulses - rp0; nwr = wr_pulses - wp0;
    $display("req we=%0d sz=%0d uns=%0d addr=%h wd=%h -> rdata=%h err=%0d lat=%0d rd=%0d wr=%0d",
             we, sz, uns, addr, wd, rd, er, lat, nrd, nwr);
  endtask

  typedef struct { bit we; logic [1:0] sz; logic [31:0] a, wd; } req_t;

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, nrd, nwr, n0, r0, t;
    req_t seq [5];
    int gaps [4];

    rst = 1; req_valid_i = 0; req_we_i = 0; req_size_i = 0; req_unsigned_i = 0;
    req_addr_i = 0; req_wdata_i = 0;
    repeat (4) @(posedge clk);
    #1 rst = 0;

    // Word store then word load
    do_req(1, 2'b10, 0, 32'h0100_0010, 32'hDEAD_BEEF, rd, er, lat, nrd, nwr);
    chk("t1_store_err", 32'(er), 0); chk("t1_store_lat", lat, 1); chk("t1_store_wr", nwr, 1);
    do_req(0, 2'b10, 0, 32'h0100_0010, 0, rd, er, lat, nrd, nwr);
    chk("t1_load_data", rd, 32'hDEAD_BEEF); chk("t1_load_err", 32'(er), 0); chk("t1_load_lat", lat, 1);

    // Byte store over that word, then signed and unsigned byte loads
    do_req(1, 2'b00, 0, 32'h0100_0011, 32'h0000_00AA, rd, er, lat, nrd, nwr);
    chk("t2_store_lat", lat, 2); chk("t2_store_rd", nrd, 1); chk("t2_store_wr", nwr, 1);
    chk("t2_mem_word", env_word(32'h10), 32'hDEAD_AAEF);
    do_req(0, 2'b00, 0, 32'h0100_0011, 0, rd, er, lat, nrd, nwr);
    chk("t2_lb_signed", rd, 32'hFFFF_FFAA);
    do_req(0, 2'b00, 1, 32'h0100_0011, 0, rd, er, lat, nrd, nwr);
    chk("t2_lb_unsigned", rd, 32'h0000_00AA);

    // Unaligned half store and signed half load
    do_req(1, 2'b01, 0, 32'h0100_0013, 32'h0000_8001, rd, er, lat, nrd, nwr);
    do_req(0, 2'b01, 0, 32'h0100_0013, 0, rd, er, lat, nrd, nwr);
    chk("t3_lh_signed", rd, 32'hFFFF_8001);
    chk("t3_low_bytes", {8'h00, env_mem[32'h12], env_mem[32'h11], env_mem[32'h10]}, 32'h00AD_AAEF);

    // Error cases: response one cycle after accept, no memory enables
    do_req(1, 2'b00, 0, BASE + DEPTH - 3, 32'h11, rd, er, lat, nrd, nwr);
    chk("t4a_err", 32'(er), 1); chk("t4a_lat", lat, 0); chk("t4a_en", nrd + nwr, 0);
    do_req(0, 2'b10, 0, BASE + DEPTH - 2, 0, rd, er, lat, nrd, nwr);
    chk("t4b_err", 32'(er), 1); chk("t4b_lat", lat, 0); chk("t4b_en", nrd + nwr, 0);
    do_req(0, 2'b00, 0, 32'h00FF_FFFF, 0, rd, er, lat, nrd, nwr);
    chk("t4c_err", 32'(er), 1); chk("t4c_rdata", rd, 0); chk("t4c_en", nrd + nwr, 0);
    do_req(0, 2'b11, 0, 32'h0100_0000, 0, rd, er, lat, nrd, nwr);
    chk("t4d_err", 32'(er), 1); chk("t4d_en", nrd + nwr, 0);
    // Boundaries that are still legal
    do_req(1, 2'b10, 0, BASE + DEPTH - 4, 32'h0BAD_F00D, rd, er, lat, nrd, nwr);
    chk("t4e_err", 32'(er), 0); chk("t4e_wr", nwr, 1);
    do_req(0, 2'b00, 1, BASE + DEPTH - 1, 0, rd, er, lat, nrd, nwr);
    chk("t4f_err", 32'(er), 0); chk("t4f_data", rd, 32'h0000_000B);

    // Back-to-back requests with valid held high
    seq[0] = '{0, 2'b10, 32'h0100_0010, 32'h0};
    seq[1] = '{1, 2'b10, 32'h0100_0020, 32'h1234_5678};
    seq[2] = '{1, 2'b00, 32'h0100_0021, 32'h0000_0055};
    seq[3] = '{0, 2'b11, 32'h0100_0000, 32'h0};
    seq[4] = '{0, 2'b10, 32'h0100_0020, 32'h0};
    gaps = '{3, 3, 4, 2};
    @(posedge clk); #1;
    n0 = acc_q.size(); r0 = rsp_count;
    req_valid_i = 1; req_unsigned_i = 0;
    for (int k = 0; k < 5; k++) begin
      req_we_i = seq[k].we; req_size_i = seq[k].sz; req_addr_i = seq[k].a; req_wdata_i = seq[k].wd;
      t = 0;
      @(negedge clk);
      while (!req_ready_o && t < 50) begin @(negedge clk); t++; end
      @(posedge clk); #1;
    end
    req_valid_i = 0;
    repeat (6) @(posedge clk);
    chk("t5_accepts", acc_q.size() - n0, 5);
    chk("t5_responses", rsp_count - r0, 5);
    if (acc_q.size() >= n0 + 5)
      for (int k = 1; k < 5; k++) begin
        chk("t5_spacing", acc_q[n0+k] - acc_q[n0+k-1], gaps[k-1]);
        $display("b2b accept %0d at edge %0d", k, acc_q[n0+k]);
      end
    chk("t5_last_rdata", last_rdata, 32'h1234_5578);

    // Reset during the WRITE cycle of a byte store
    @(posedge clk); #1;
    r0 = rsp_count;
    req_valid_i = 1; req_we_i = 1; req_size_i = 2'b00; req_addr_i = 32'h0100_0020; req_wdata_i = 32'h99;
    @(negedge clk);
    chk("t6_ready", 32'(req_ready_o), 1);
    @(posedge clk); #1 req_valid_i = 0;
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("t6_wr_gated", 32'(mem_write_en_o), 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("t6_ready_after", 32'(req_ready_o), 1);
    repeat (2) @(posedge clk);
    chk("t6_no_rsp", rsp_count - r0, 0);
    chk("t6_mem_word", env_word(32'h20), 32'h1234_5578);
    $display("reset mid-store: rsp=%0d mem=%h", rsp_count - r0, env_word(32'h20));
    do_req(0, 2'b10, 0, 32'h0100_0020, 0, rd, er, lat, nrd, nwr);
    chk("t6_load", rd, 32'h1234_5578); chk("t6_load_err", 32'(er), 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
